// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - byte type and Rijndael ShiftRows helpers shared by the srows pipeline
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam int MAX_NB = 8;
    localparam int MAX_W  = 32 * MAX_NB;

    function automatic int srows_offset(input int nb, input int r);
        return (nb == 8 && r >= 2) ? r + 1 : r;
    endfunction

    // Works on the low 32*nb bits of a max-width vector; nb is a constant at every call site.
    function automatic logic [MAX_W-1:0] shift_state(input logic [MAX_W-1:0] state,
                                                     input int nb, input logic inverse);
        logic [MAX_W-1:0] res;
        logic [7:0]       src_idx;
        logic [7:0]       dst_idx;
        int               src_c;
        byte_t            b;
        res = '0;
        for (int c = 0; c < MAX_NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (c < nb) begin
                    src_c   = inverse ? (c - srows_offset(nb, r) + nb) % nb
                                      : (c + srows_offset(nb, r)) % nb;
                    src_idx = 8'(32 * nb - 1 - 8 * (4 * src_c + r));
                    dst_idx = 8'(32 * nb - 1 - 8 * (4 * c + r));
                    b       = state[src_idx -: 8];
                    res[dst_idx -: 8] = b;
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/srows_stage.sv
// rtl/srows_stage.sv - one elastic register slice carrying data, inverse tag and valid
module srows_stage #(
    parameter int W = 128
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    input  logic         inv_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic         inv_o
);

    logic         valid_q, valid_d;
    logic         inv_q, inv_d;
    logic [W-1:0] data_q, data_d;

    assign ready_o = !valid_q || ready_i;

    // Payload only moves with a real transfer so held outputs never glitch on bubbles.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        inv_d   = inv_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (ready_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
                inv_d  = inv_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            inv_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            inv_q   <= inv_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign inv_o   = inv_q;

endmodule

// File: rtl/srows_pipe.sv
// rtl/srows_pipe.sv - parametrised ShiftRows/InvShiftRows with an elastic valid/ready pipeline
module srows_pipe
    import aes_pkg::*;
#(
    parameter int NB     = 4,
    parameter int STAGES = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             srows_clear,
    input  logic                             srows_enable,
    output logic                             srows_ready,
    input  logic [32*NB-1:0]                 olddata,
    input  logic                             inverse,
    output logic                             srows_finished,
    input  logic                             srows_accept,
    output logic [32*NB-1:0]                 newdata,
    output logic [$clog2(STAGES+1)-1:0]      inflight
);

    localparam int W  = 32 * NB;
    localparam int CW = $clog2(STAGES + 1);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("srows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("srows_pipe: STAGES must be 1..4");
    end

    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [W-1:0]    dat   [STAGES+1];
    logic            inv_t [STAGES+1];
    logic [W-1:0]    shifted;

    assign shifted  = W'(shift_state(MAX_W'(olddata), NB, inverse));

    // Clear both blocks the incoming beat and hides ready from the source.
    assign vld[0]   = srows_enable && !srows_clear;
    assign dat[0]   = shifted;
    assign inv_t[0] = inverse;
    assign rdy[STAGES] = srows_accept;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        srows_stage #(.W(W)) u_stage (
            .clk     (clk),
            .rst     (rst),
            .clear_i (srows_clear),
            .valid_i (vld[i]),
            .ready_o (rdy[i]),
            .data_i  (dat[i]),
            .inv_i   (inv_t[i]),
            .valid_o (vld[i+1]),
            .ready_i (rdy[i+1]),
            .data_o  (dat[i+1]),
            .inv_o   (inv_t[i+1])
        );
    end

    assign srows_ready    = rdy[0] && !srows_clear;
    assign srows_finished = vld[STAGES];
    assign newdata        = dat[STAGES];

    always_comb begin
        inflight = '0;
        for (int i = 1; i <= STAGES; i++) begin
            inflight = inflight + CW'(vld[i]);
        end
    end

endmodule

// File: tb/tb_srows_pipe.sv
// tb/tb_srows_pipe.sv - scoreboard bench for srows_pipe in three configurations
module tb_srows_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // a: NB=4 STAGES=1, b: NB=8 STAGES=3, c: NB=4 STAGES=2
    logic         clr_a = 0, en_a = 0, inv_a = 0, acc_a = 0, rdy_a, fin_a;
    logic [127:0] old_a = '0, new_a;
    logic [0:0]   inf_a;
    logic         clr_b = 0, en_b = 0, inv_b = 0, acc_b = 0, rdy_b, fin_b;
    logic [255:0] old_b = '0, new_b;
    logic [1:0]   inf_b;
    logic         clr_c = 0, en_c = 0, inv_c = 0, acc_c = 0, rdy_c, fin_c;
    logic [127:0] old_c = '0, new_c;
    logic [1:0]   inf_c;

    srows_pipe #(.NB(4), .STAGES(1)) u_a (
        .clk(clk), .rst(rst), .srows_clear(clr_a), .srows_enable(en_a), .srows_ready(rdy_a),
        .olddata(old_a), .inverse(inv_a), .srows_finished(fin_a), .srows_accept(acc_a),
        .newdata(new_a), .inflight(inf_a));
    srows_pipe #(.NB(8), .STAGES(3)) u_b (
        .clk(clk), .rst(rst), .srows_clear(clr_b), .srows_enable(en_b), .srows_ready(rdy_b),
        .olddata(old_b), .inverse(inv_b), .srows_finished(fin_b), .srows_accept(acc_b),
        .newdata(new_b), .inflight(inf_b));
    srows_pipe #(.NB(4), .STAGES(2)) u_c (
        .clk(clk), .rst(rst), .srows_clear(clr_c), .srows_enable(en_c), .srows_ready(rdy_c),
        .olddata(old_c), .inverse(inv_c), .srows_finished(fin_c), .srows_accept(acc_c),
        .newdata(new_c), .inflight(inf_c));

    logic [255:0] qa_d[$], qb_d[$], qc_d[$];
    int           qa_t[$], qb_t[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: rotate each row of a byte matrix by its offset.
    function automatic logic [255:0] ref_shift(input logic [255:0] s, input int nb, input bit inv);
        logic [7:0]   m [4][8];
        int           off [4];
        logic [255:0] o;
        logic [7:0]   idx;
        int           k;
        if (nb == 8) off = '{0, 1, 3, 4};
        else         off = '{0, 1, 2, 3};
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) begin
                idx = 8'(32 * nb - 1 - 8 * (4 * c + r));
                m[r][c] = s[idx -: 8];
            end
        o = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) begin
                k   = inv ? (c + nb - off[r]) % nb : (c + off[r]) % nb;
                idx = 8'(32 * nb - 1 - 8 * (4 * c + r));
                o[idx -: 8] = m[r][k];
            end
        return o;
    endfunction

    function automatic logic [255:0] rnd();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (fin_a && acc_a) begin
                chk("a_out_expected", 256'(qa_d.size() > 0), 256'(1));
                if (qa_d.size() > 0) begin
                    chk("a_data", 256'(new_a), qa_d.pop_front());
                    chk("a_latency", 256'(cyc - qa_t.pop_front()), 256'(1));
                end
            end
            if (fin_b && acc_b) begin
                chk("b_out_expected", 256'(qb_d.size() > 0), 256'(1));
                if (qb_d.size() > 0) begin
                    chk("b_data", new_b, qb_d.pop_front());
                    chk("b_latency", 256'(cyc - qb_t.pop_front()), 256'(3));
                end
            end
            if (fin_c && acc_c) begin
                chk("c_out_expected", 256'(qc_d.size() > 0), 256'(1));
                if (qc_d.size() > 0) chk("c_data", 256'(new_c), qc_d.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] x1, e1, e2, snap, dblk;
        logic [127:0] cv [6];
        logic [255:0] xb, yb, tmp;
        int k;
        x1 = 128'h112233445566778899AABBCCDDEEFF00;
        e1 = 128'h1166BB0055AAFF4499EE3388DD2277CC;
        e2 = 128'h11EEBB885522FFCC99663300DDAA7744;

        #12;
        chk("rst_fin_a", 256'(fin_a), 256'(0));
        chk("rst_new_a", 256'(new_a), 256'(0));
        chk("rst_inf_a", 256'(inf_a), 256'(0));
        chk("rst_fin_b", 256'(fin_b), 256'(0));
        chk("rst_new_b", new_b, 256'(0));
        chk("rst_inf_c", 256'(inf_c), 256'(0));
        @(posedge clk); #2 rst = 1'b0;
        #1;
        chk("rdy_a_after_rst", 256'(rdy_a), 256'(1));
        chk("rdy_b_after_rst", 256'(rdy_b), 256'(1));
        chk("rdy_c_after_rst", 256'(rdy_c), 256'(1));
        acc_a = 1; acc_b = 1; acc_c = 1;
        @(posedge clk); #2;

        // Known forward vector, finished one cycle after accept
        en_a = 1; inv_a = 0; old_a = x1;
        qa_d.push_back(256'(e1)); qa_t.push_back(cyc);
        @(posedge clk); #2;
        en_a = 0;
        chk("t1_finished", 256'(fin_a), 256'(1));
        @(posedge clk); #2;

        // Inverse vector, then round trip of the forward result
        en_a = 1; inv_a = 1; old_a = x1;
        qa_d.push_back(256'(e2)); qa_t.push_back(cyc);
        @(posedge clk); #2;
        old_a = e1;
        qa_d.push_back(256'(x1)); qa_t.push_back(cyc);
        @(posedge clk); #2;
        en_a = 0;
        repeat (3) @(posedge clk);
        #2;

        // Clear flushes a held beat and refuses the concurrent input
        acc_a = 0; en_a = 1; inv_a = 0; old_a = x1;
        @(posedge clk); #2;
        chk("t6_inflight_before", 256'(inf_a), 256'(1));
        clr_a = 1; old_a = e2;
        #1 chk("t6_ready_low", 256'(rdy_a), 256'(0));
        @(posedge clk); #2;
        clr_a = 0; en_a = 0;
        chk("t6_inflight_after", 256'(inf_a), 256'(0));
        chk("t6_finished_after", 256'(fin_a), 256'(0));
        acc_a = 1;
        repeat (3) @(posedge clk);
        #2;

        // NB=8 STAGES=3: forward then inverse back-to-back
        for (int i = 0; i < 4; i++) begin
            xb = rnd();
            yb = ref_shift(xb, 8, 1'b0);
            en_b = 1; inv_b = 0; old_b = xb;
            qb_d.push_back(yb); qb_t.push_back(cyc);
            @(posedge clk); #2;
            inv_b = 1; old_b = yb;
            qb_d.push_back(xb); qb_t.push_back(cyc);
            @(posedge clk); #2;
        end
        en_b = 0;
        repeat (6) @(posedge clk);
        #2;

        // STAGES=2 backpressure
        for (int i = 0; i < 6; i++) begin
            tmp = rnd();
            cv[i] = tmp[127:0];
        end
        acc_c = 0; k = 0;
        for (int t = 0; t < 5; t++) begin
            en_c = 1; old_c = cv[k]; inv_c = k[0];
            #1;
            if (rdy_c) begin
                qc_d.push_back(ref_shift(256'(cv[k]), 4, k[0]));
                k++;
            end
            @(posedge clk); #2;
            if (t == 1) snap = new_c;
        end
        chk("t4_accepted", 256'(k), 256'(2));
        chk("t4_ready_low", 256'(rdy_c), 256'(0));
        chk("t4_inflight", 256'(inf_c), 256'(2));
        chk("t4_finished", 256'(fin_c), 256'(1));
        chk("t4_stable", 256'(new_c), 256'(snap));
        acc_c = 1;
        for (int t = 0; t < 40 && k < 6; t++) begin
            en_c = 1; old_c = cv[k]; inv_c = k[0];
            #1;
            if (rdy_c) begin
                qc_d.push_back(ref_shift(256'(cv[k]), 4, k[0]));
                k++;
            end
            @(posedge clk); #2;
        end
        chk("t4_all_sent", 256'(k), 256'(6));
        en_c = 0;
        repeat (4) @(posedge clk);
        #2;
        chk("t4_drained", 256'(qc_d.size()), 256'(0));
        chk("t4_inflight_end", 256'(inf_c), 256'(0));

        // Async reset mid-stream
        acc_c = 0; en_c = 1; inv_c = 0; old_c = cv[0];
        @(posedge clk); #2;
        old_c = cv[1];
        @(posedge clk); #2;
        en_c = 0;
        chk("t5_inflight_pre", 256'(inf_c), 256'(2));
        #1 rst = 1'b1;
        #1;
        chk("t5_fin_rst", 256'(fin_c), 256'(0));
        chk("t5_new_rst", 256'(new_c), 256'(0));
        chk("t5_inf_rst", 256'(inf_c), 256'(0));
        @(posedge clk); #2 rst = 1'b0;
        #1 chk("t5_rdy_after", 256'(rdy_c), 256'(1));
        dblk = cv[5];
        acc_c = 1; en_c = 1; inv_c = 0; old_c = dblk;
        qc_d.push_back(ref_shift(256'(dblk), 4, 1'b0));
        @(posedge clk); #2;
        en_c = 0;
        repeat (4) @(posedge clk);
        #2;
        chk("t5_single_out", 256'(qc_d.size()), 256'(0));
        chk("qa_empty", 256'(qa_d.size()), 256'(0));
        chk("qb_empty", 256'(qb_d.size()), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
